mips_run_ctrl: RTL
==================

// Module: mips_run_ctrl
// PURPOSE
//  Run/halt/single-step sequencer between MIPS_CTRL and MIPS_dataPath.
//  - Gates the controller's pc_en, reg_w_en and dmem_w_en before they reach the datapath.
//  - Provides a PC breakpoint plus cycle and instruction counters for bring-up and debug.
//  - Sits at MIPSCheck level; MIPS_CTRL and MIPS_dataPath are unchanged.
// PARAMETERS
//  AW           32  PC width; matches the datapath count bus
//  CW           32  width of cycle_cnt / instr_cnt
//  STEP_CYCLES  1   enabled clock cycles per step request (>=1)
// PORTS
//  clk            in   1   clock; all state updates on posedge clk
//  rst            in   1   synchronous, active-high reset
//  run_req        in   1   enter RUN (level, sampled each cycle)
//  halt_req       in   1   enter HALT (level); highest priority
//  step_req       in   1   start one step burst (level)
//  bp_en          in   1   breakpoint enable
//  bp_addr        in   AW  breakpoint PC value
//  pc             in   AW  current PC (datapath count)
//  user           in   1   user display mode; freezes the counters
//  cnt_clr        in   1   clear both counters
//  pc_en_in       in   1   from MIPS_CTRL
//  reg_w_en_in    in   1   from MIPS_CTRL
//  dmem_w_en_in   in   1   from MIPS_CTRL
//  pc_en_out      out  1   to MIPS_dataPath
//  reg_w_en_out   out  1   to MIPS_dataPath
//  dmem_w_en_out  out  1   to MIPS_dataPath
//  state          out  2   00 HALT, 01 RUN, 10 STEP, 11 BRK
//  halted         out  1   1 when state is HALT or BRK
//  bp_hit         out  1   one-cycle pulse on the cycle RUN->BRK is taken
//  cycle_cnt      out  CW  count of active cycles
//  instr_cnt      out  CW  count of cycles with pc_en_out=1
// BEHAVIOUR
//  Reset (rst=1 at posedge), every output at reset:
//   - state=HALT, halted=1, bp_hit=0, cycle_cnt=0, instr_cnt=0, step count=0.
//   - The three gated enables are 0 while in HALT.
//   - rst overrides every request in the same cycle, including mid-STEP or in BRK.
//  Breakpoint match:
//   - match = bp_en & (pc==bp_addr) & (pc != pc_q). pc_q is pc registered last cycle.
//   - The pc_q term means resuming at the breakpoint address does not re-trigger.
//   - pc_q is reset to {AW{1'b1}}, so bp_addr=0 can hit straight after reset.
//  active = (state==RUN & ~match) | (state==STEP).
//   - Each *_out = its *_in & active. Combinational; no added latency.
//   - A matched instruction does not execute: its enables are blocked that same cycle.
//  Next-state priority: halt_req > step_req > run_req. Per state:
//   - HALT: step_req -> STEP and load step count = STEP_CYCLES; run_req -> RUN.
//   - RUN: halt_req -> HALT; match -> BRK with bp_hit=1 that cycle;
//     step_req is ignored; otherwise stay in RUN.
//   - STEP: decrement the step count each cycle. halt_req -> HALT (aborts the burst).
//     When the count reaches 1 -> HALT, so exactly STEP_CYCLES active cycles run.
//     Requests are not re-sampled until the burst ends.
//     step_req still high on return to HALT starts a new burst: the bench must pulse it.
//     Breakpoints are not checked in STEP.
//   - BRK: halt_req -> HALT; step_req -> STEP; run_req -> RUN.
//  Counters:
//   - cycle_cnt += 1 when active & ~user.
//   - instr_cnt += 1 when pc_en_out & ~user.
//   - Both saturate at all-ones (no wrap).
//   - cnt_clr wins over an increment in the same cycle.
//  MIPS_CTRL already forces its enables to 0 when user=1, so gating needs no user term.
// TESTING
//  T1 Reset: rst=1 for 2 cycles with run_req=1 -> state=00, halted=1, all *_out=0, counters 0.
//  T2 Run: run_req=1, pc_en_in=1 for 10 cycles -> state=01, pc_en_out=1, cycle_cnt=10, instr_cnt=10.
//  T3 Breakpoint: RUN, bp_en=1, bp_addr=5, pc steps 3,4,5.
//     -> at pc=5: bp_hit pulses, pc_en_out=0 that cycle, state=11 next cycle.
//     -> then run_req with pc still 5 -> RUN, no new hit, pc_en_out=1.
//  T4 Step: STEP_CYCLES=3, HALT, pulse step_req 1 cycle.
//     -> pc_en_out=1 for exactly 3 cycles, then state=00, instr_cnt=3.
//  T5 Priority/abort: halt_req and step_req together from BRK -> HALT.
//     -> halt_req on the 2nd STEP cycle -> HALT next cycle, instr_cnt=2.
//  T6 Counters: CW=4, RUN 20 cycles -> cycle_cnt=15 (saturated).
//     -> cnt_clr with an increment in the same cycle -> 0.
//     -> user=1 -> counters hold.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Run/halt/single-step sequencer that gates MIPS_CTRL enables into MIPS_dataPath,
// with a PC breakpoint and saturating cycle/instruction counters for bring-up.
module mips_run_ctrl #(
    parameter int AW          = 32,
    parameter int CW          = 32,
    parameter int STEP_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_req,
    input  logic          halt_req,
    input  logic          step_req,
    input  logic          bp_en,
    input  logic [AW-1:0] bp_addr,
    input  logic [AW-1:0] pc,
    input  logic          user,
    input  logic          cnt_clr,
    input  logic          pc_en_in,
    input  logic          reg_w_en_in,
    input  logic          dmem_w_en_in,
    output logic          pc_en_out,
    output logic          reg_w_en_out,
    output logic          dmem_w_en_out,
    output logic [1:0]    state,
    output logic          halted,
    output logic          bp_hit,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] instr_cnt
);
    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES);

    state_t        st, st_nx;
    logic [SW-1:0] step_cnt, step_cnt_nx;
    logic [AW-1:0] pc_q;
    logic          match, active, hit_c;

    // pc_q keeps a PC that is parked on the breakpoint from re-triggering after resume
    assign match  = bp_en & (pc == bp_addr) & (pc != pc_q);
    assign active = ((st == S_RUN) & ~match) | (st == S_STEP);

    assign pc_en_out     = pc_en_in & active;
    assign reg_w_en_out  = reg_w_en_in & active;
    assign dmem_w_en_out = dmem_w_en_in & active;
    assign state         = st;
    assign halted        = (st == S_HALT) | (st == S_BRK);
    assign bp_hit        = hit_c & ~rst;

    always_comb begin
        st_nx       = st;
        step_cnt_nx = step_cnt;
        hit_c       = 1'b0;
        case (st)
            S_HALT, S_BRK: begin
                if (halt_req) begin
                    st_nx = S_HALT;
                end else if (step_req) begin
                    st_nx       = S_STEP;
                    step_cnt_nx = STEP_LOAD;
                end else if (run_req) begin
                    st_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (halt_req) begin
                    st_nx = S_HALT;
                end else if (match) begin
                    st_nx = S_BRK;
                    hit_c = 1'b1;
                end
            end
            S_STEP: begin
                step_cnt_nx = step_cnt - 1'b1;
                if (halt_req || step_cnt <= SW'(1)) st_nx = S_HALT;
            end
            default: st_nx = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_HALT;
            step_cnt <= '0;
            pc_q     <= {AW{1'b1}};
        end else begin
            st       <= st_nx;
            step_cnt <= step_cnt_nx;
            pc_q     <= pc;
        end
    end

    // Counters saturate at all-ones; clear beats increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (active && !user && !(&cycle_cnt))    cycle_cnt <= cycle_cnt + 1'b1;
            if (pc_en_out && !user && !(&instr_cnt)) instr_cnt <= instr_cnt + 1'b1;
        end
    end
endmodule
